// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the collision/scoring stage
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EVAL,
      ST_HIT,
      ST_LOCKOUT
   } collision_state_e;

   typedef logic [3:0] bcd_digit_t;

   typedef struct packed {
      logic [9:0] left;
      logic [9:0] right;
      logic [9:0] top;
      logic [9:0] bot;
   } box_t;

   localparam logic [15:0] SCORE_MAX_C = 16'h9999;

endpackage

// File: rtl/bcd_counter4.sv
// rtl/bcd_counter4.sv - four-digit BCD counter, increments by one and saturates at 9999
module bcd_counter4
   import game_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        inc_i,
   output logic [15:0] count_o
);

   logic [15:0] count_q, count_d;
   bcd_digit_t  digit;
   logic        carry;

   always_comb begin
      count_d = count_q;
      digit   = '0;
      carry   = 1'b0;
      if (inc_i && (count_q != SCORE_MAX_C)) begin
         carry = 1'b1;
         for (int i = 0; i < 4; i++) begin
            digit = count_q[i*4 +: 4];
            if (carry) begin
               if (digit == 4'd9) begin
                  digit = 4'd0;
               end else begin
                  digit = digit + 4'd1;
                  carry = 1'b0;
               end
            end
            count_d[i*4 +: 4] = digit;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/collision_scorer.sv
// rtl/collision_scorer.sv - per-frame bullet/enemy hit detection, BCD score, life awards and landing detection
module collision_scorer
   import game_pkg::*;
#(
   parameter int unsigned life_interval_p = 10
)
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        frame_i,
   input  logic        bullet_valid_i,
   input  logic [9:0]  bullet_left_i,
   input  logic [9:0]  bullet_right_i,
   input  logic [9:0]  bullet_top_i,
   input  logic [9:0]  bullet_bot_i,
   input  logic [9:0]  enemy_left_i,
   input  logic [9:0]  enemy_right_i,
   input  logic [9:0]  enemy_top_i,
   input  logic [9:0]  enemy_bot_i,
   input  logic        enemy_dead_i,
   input  logic        enemy_landed_i,
   output logic        hit_enemy_o,
   output logic        enemy_hit_o,
   output logic        player_hit_o,
   output logic        add_life_o,
   output logic        game_over_o,
   output logic [15:0] score_bcd_o
);

   localparam logic [7:0] KILL_LAST_C = 8'(life_interval_p - 1);

   collision_state_e state_q, state_d;
   box_t             bullet_q, bullet_d, enemy_q, enemy_d;
   logic             valid_q, valid_d, dead_q, dead_d;
   logic             hit_q, hit_d, add_life_q, add_life_d;
   logic             player_hit_q, player_hit_d, game_over_q, game_over_d;
   logic             landed_q, landed_d;
   logic [7:0]       kill_q, kill_d;
   logic             overlap;

   // Strict compares: boxes sharing only an edge do not collide.
   assign overlap = (bullet_q.left < enemy_q.right) && (enemy_q.left < bullet_q.right) &&
                    (bullet_q.top  < enemy_q.bot)   && (enemy_q.top  < bullet_q.bot);

   always_comb begin
      state_d  = state_q;
      bullet_d = bullet_q;
      enemy_d  = enemy_q;
      valid_d  = valid_q;
      dead_d   = dead_q;
      hit_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (frame_i) begin
               bullet_d = '{bullet_left_i, bullet_right_i, bullet_top_i, bullet_bot_i};
               enemy_d  = '{enemy_left_i, enemy_right_i, enemy_top_i, enemy_bot_i};
               valid_d  = bullet_valid_i;
               dead_d   = enemy_dead_i;
               state_d  = ST_EVAL;
            end
         end
         ST_EVAL: begin
            if (overlap && valid_q && !dead_q && !game_over_q) begin
               hit_d   = 1'b1;
               state_d = ST_HIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HIT: state_d = ST_LOCKOUT;
         ST_LOCKOUT: begin
            if (!bullet_valid_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      kill_d     = kill_q;
      add_life_d = 1'b0;
      if (hit_d) begin
         if (kill_q == KILL_LAST_C) begin
            kill_d     = '0;
            add_life_d = 1'b1;
         end else begin
            kill_d = kill_q + 8'd1;
         end
      end
   end

   // Landing is edge-detected on its own, regardless of the FSM state.
   always_comb begin
      landed_d     = enemy_landed_i;
      player_hit_d = enemy_landed_i && !landed_q;
      game_over_d  = game_over_q || player_hit_d;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         bullet_q     <= '0;
         enemy_q      <= '0;
         valid_q      <= 1'b0;
         dead_q       <= 1'b0;
         hit_q        <= 1'b0;
         add_life_q   <= 1'b0;
         kill_q       <= '0;
         landed_q     <= 1'b0;
         player_hit_q <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bullet_q     <= bullet_d;
         enemy_q      <= enemy_d;
         valid_q      <= valid_d;
         dead_q       <= dead_d;
         hit_q        <= hit_d;
         add_life_q   <= add_life_d;
         kill_q       <= kill_d;
         landed_q     <= landed_d;
         player_hit_q <= player_hit_d;
         game_over_q  <= game_over_d;
      end
   end

   bcd_counter4 u_score (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (hit_d),
      .count_o (score_bcd_o)
   );

   assign hit_enemy_o  = hit_q;
   assign enemy_hit_o  = hit_q;
   assign add_life_o   = add_life_q;
   assign player_hit_o = player_hit_q;
   assign game_over_o  = game_over_q;

endmodule

// File: tb/tb_collision_scorer.sv
// tb/tb_collision_scorer.sv - directed self-checking bench for collision_scorer
module tb_collision_scorer;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        frame_i = 1'b0;
   logic        bullet_valid_i = 1'b0;
   logic [9:0]  bullet_left_i = '0, bullet_right_i = '0, bullet_top_i = '0, bullet_bot_i = '0;
   logic [9:0]  enemy_left_i = '0, enemy_right_i = '0, enemy_top_i = '0, enemy_bot_i = '0;
   logic        enemy_dead_i = 1'b0;
   logic        enemy_landed_i = 1'b0;
   logic        hit_enemy_o, enemy_hit_o, player_hit_o, add_life_o, game_over_o;
   logic [15:0] score_bcd_o;

   int n_cmp = 0;
   int n_err = 0;

   collision_scorer #(.life_interval_p(3)) u_dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .frame_i        (frame_i),
      .bullet_valid_i (bullet_valid_i),
      .bullet_left_i  (bullet_left_i),
      .bullet_right_i (bullet_right_i),
      .bullet_top_i   (bullet_top_i),
      .bullet_bot_i   (bullet_bot_i),
      .enemy_left_i   (enemy_left_i),
      .enemy_right_i  (enemy_right_i),
      .enemy_top_i    (enemy_top_i),
      .enemy_bot_i    (enemy_bot_i),
      .enemy_dead_i   (enemy_dead_i),
      .enemy_landed_i (enemy_landed_i),
      .hit_enemy_o    (hit_enemy_o),
      .enemy_hit_o    (enemy_hit_o),
      .player_hit_o   (player_hit_o),
      .add_life_o     (add_life_o),
      .game_over_o    (game_over_o),
      .score_bcd_o    (score_bcd_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_boxes(input logic [9:0] bl, br, bt, bb, el, er, et, eb);
      bullet_left_i = bl; bullet_right_i = br; bullet_top_i = bt; bullet_bot_i = bb;
      enemy_left_i  = el; enemy_right_i  = er; enemy_top_i  = et; enemy_bot_i  = eb;
   endtask

   task automatic set_overlap();
      set_boxes(10'd300, 10'd306, 10'd200, 10'd210, 10'd290, 10'd330, 10'd190, 10'd220);
   endtask

   task automatic apply_reset();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
   endtask

   // One full kill from IDLE: frame, EVAL, HIT (sampled), LOCKOUT released, back in IDLE.
   task automatic kill(output logic h_e, output logic e_h, output logic life, output logic [15:0] score);
      bullet_valid_i = 1'b1;
      frame_i = 1'b1;
      tick();
      frame_i = 1'b0;
      tick();
      h_e = hit_enemy_o; e_h = enemy_hit_o; life = add_life_o; score = score_bcd_o;
      bullet_valid_i = 1'b0;
      tick();
      tick();
      bullet_valid_i = 1'b1;
   endtask

   // Pulse frame once and count cycles with a hit pulse over the following window.
   task automatic frame_count(output int hits);
      hits = 0;
      frame_i = 1'b1;
      tick();
      frame_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (hit_enemy_o || enemy_hit_o) hits++;
         tick();
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      tick();
      tick();
      reset_i = 1'b0;
      n_cmp++;
      if ({hit_enemy_o, enemy_hit_o, player_hit_o, add_life_o, game_over_o} !== 5'b0 || score_bcd_o !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_state: flags=%b score=%h, required flags=00000 score=0000",
                  {hit_enemy_o, enemy_hit_o, player_hit_o, add_life_o, game_over_o}, score_bcd_o);
      end
   endtask

   task automatic test_direct_hit();
      apply_reset();
      set_overlap();
      bullet_valid_i = 1'b1;
      frame_i = 1'b1;
      tick();
      frame_i = 1'b0;
      n_cmp++;
      if (hit_enemy_o !== 1'b0 || enemy_hit_o !== 1'b0 || score_bcd_o !== 16'h0000) begin
         n_err++;
         $display("FAIL hit_eval_cycle: hit=%b/%b score=%h, required 0/0 0000", hit_enemy_o, enemy_hit_o, score_bcd_o);
      end
      tick();
      n_cmp++;
      if (hit_enemy_o !== 1'b1 || enemy_hit_o !== 1'b1 || score_bcd_o !== 16'h0001 || add_life_o !== 1'b0) begin
         n_err++;
         $display("FAIL hit_k2: hit=%b/%b life=%b score=%h, required 1/1 0 0001",
                  hit_enemy_o, enemy_hit_o, add_life_o, score_bcd_o);
      end
      tick();
      n_cmp++;
      if (hit_enemy_o !== 1'b0 || enemy_hit_o !== 1'b0 || score_bcd_o !== 16'h0001) begin
         n_err++;
         $display("FAIL hit_one_cycle: hit=%b/%b score=%h, required 0/0 0001", hit_enemy_o, enemy_hit_o, score_bcd_o);
      end
   endtask

   task automatic test_miss();
      int hits;
      bullet_valid_i = 1'b0;
      tick();
      tick();
      bullet_valid_i = 1'b1;
      set_boxes(10'd284, 10'd290, 10'd200, 10'd210, 10'd290, 10'd330, 10'd190, 10'd220);
      frame_count(hits);
      n_cmp++;
      if (hits !== 0) begin
         n_err++;
         $display("FAIL miss_x_edge: hits=%0d, required 0", hits);
      end
      set_boxes(10'd300, 10'd306, 10'd220, 10'd230, 10'd290, 10'd330, 10'd190, 10'd220);
      frame_count(hits);
      n_cmp++;
      if (hits !== 0) begin
         n_err++;
         $display("FAIL miss_y_edge: hits=%0d, required 0", hits);
      end
      set_overlap();
      enemy_dead_i = 1'b1;
      frame_count(hits);
      enemy_dead_i = 1'b0;
      n_cmp++;
      if (hits !== 0) begin
         n_err++;
         $display("FAIL miss_dead: hits=%0d, required 0", hits);
      end
      bullet_valid_i = 1'b0;
      frame_count(hits);
      n_cmp++;
      if (hits !== 0 || score_bcd_o !== 16'h0001) begin
         n_err++;
         $display("FAIL miss_invalid: hits=%0d score=%h, required 0 0001", hits, score_bcd_o);
      end
   endtask

   task automatic test_lockout();
      int hits, total;
      apply_reset();
      set_overlap();
      bullet_valid_i = 1'b1;
      total = 0;
      for (int f = 0; f < 3; f++) begin
         frame_count(hits);
         total += hits;
      end
      n_cmp++;
      if (total !== 1 || score_bcd_o !== 16'h0001) begin
         n_err++;
         $display("FAIL lockout_single: hits=%0d score=%h, required 1 0001", total, score_bcd_o);
      end
      bullet_valid_i = 1'b0;
      tick();
      bullet_valid_i = 1'b1;
      frame_count(hits);
      n_cmp++;
      if (hits !== 1 || score_bcd_o !== 16'h0002) begin
         n_err++;
         $display("FAIL lockout_release: hits=%0d score=%h, required 1 0002", hits, score_bcd_o);
      end
   endtask

   task automatic test_life();
      logic h_e, e_h, life;
      logic [15:0] score;
      apply_reset();
      set_overlap();
      for (int k = 1; k <= 7; k++) begin
         kill(h_e, e_h, life, score);
         n_cmp++;
         if (h_e !== 1'b1 || e_h !== 1'b1 || life !== ((k == 3) || (k == 6))) begin
            n_err++;
            $display("FAIL life_kill%0d: hit=%b/%b life=%b, required 1/1 %b", k, h_e, e_h, life, (k == 3) || (k == 6));
         end
      end
      n_cmp++;
      if (score_bcd_o !== 16'h0007) begin
         n_err++;
         $display("FAIL life_score: score=%h, required 0007", score_bcd_o);
      end
   endtask

   task automatic test_saturation();
      logic h_e, e_h, life;
      logic [15:0] score;
      apply_reset();
      set_overlap();
      for (int k = 0; k < 9998; k++) kill(h_e, e_h, life, score);
      n_cmp++;
      if (score_bcd_o !== 16'h9998) begin
         n_err++;
         $display("FAIL sat_9998: score=%h, required 9998", score_bcd_o);
      end
      kill(h_e, e_h, life, score);
      n_cmp++;
      if (h_e !== 1'b1 || score !== 16'h9999) begin
         n_err++;
         $display("FAIL sat_9999: hit=%b score=%h, required 1 9999", h_e, score);
      end
      kill(h_e, e_h, life, score);
      n_cmp++;
      if (h_e !== 1'b1 || e_h !== 1'b1 || score !== 16'h9999) begin
         n_err++;
         $display("FAIL sat_hold: hit=%b/%b score=%h, required 1/1 9999", h_e, e_h, score);
      end
   endtask

   task automatic test_landing_reset();
      int hits, pulses;
      enemy_landed_i = 1'b1;
      tick();
      n_cmp++;
      if (player_hit_o !== 1'b1 || game_over_o !== 1'b1) begin
         n_err++;
         $display("FAIL land_pulse: player_hit=%b game_over=%b, required 1 1", player_hit_o, game_over_o);
      end
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (player_hit_o) pulses++;
      end
      enemy_landed_i = 1'b0;
      n_cmp++;
      if (pulses !== 0 || game_over_o !== 1'b1) begin
         n_err++;
         $display("FAIL land_once: extra_pulses=%0d game_over=%b, required 0 1", pulses, game_over_o);
      end
      set_overlap();
      bullet_valid_i = 1'b1;
      frame_count(hits);
      n_cmp++;
      if (hits !== 0 || score_bcd_o !== 16'h9999 || game_over_o !== 1'b1) begin
         n_err++;
         $display("FAIL gameover_nohit: hits=%0d score=%h game_over=%b, required 0 9999 1", hits, score_bcd_o, game_over_o);
      end
      apply_reset();
      n_cmp++;
      if (game_over_o !== 1'b0 || score_bcd_o !== 16'h0000) begin
         n_err++;
         $display("FAIL gameover_clear: game_over=%b score=%h, required 0 0000", game_over_o, score_bcd_o);
      end
      frame_i = 1'b1;
      tick();
      frame_i = 1'b0;
      enemy_landed_i = 1'b1;
      tick();
      n_cmp++;
      if (hit_enemy_o !== 1'b1 || player_hit_o !== 1'b1 || game_over_o !== 1'b1 || score_bcd_o !== 16'h0001) begin
         n_err++;
         $display("FAIL land_with_hit: hit=%b player_hit=%b game_over=%b score=%h, required 1 1 1 0001",
                  hit_enemy_o, player_hit_o, game_over_o, score_bcd_o);
      end
      tick();
      reset_i = 1'b1;
      tick();
      enemy_landed_i = 1'b0;
      n_cmp++;
      if ({hit_enemy_o, enemy_hit_o, player_hit_o, add_life_o, game_over_o} !== 5'b0 || score_bcd_o !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_lockout: flags=%b score=%h, required 00000 0000",
                  {hit_enemy_o, enemy_hit_o, player_hit_o, add_life_o, game_over_o}, score_bcd_o);
      end
      reset_i = 1'b0;
      frame_count(hits);
      n_cmp++;
      if (hits !== 1 || score_bcd_o !== 16'h0001) begin
         n_err++;
         $display("FAIL reset_to_idle: hits=%0d score=%h, required 1 0001", hits, score_bcd_o);
      end
   endtask

   initial begin
      test_reset();
      test_direct_hit();
      test_miss();
      test_lockout();
      test_life();
      test_saturation();
      test_landing_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/collision_scorer.md
# collision_scorer

Per-frame hit-detection and scoring stage that sits between the player/bullet block and the enemy block in the game core. Once per video frame it compares the player bullet's bounding box with the enemy's bounding box and issues one-cycle hit pulses to both blocks. It also runs a saturating 4-digit BCD score, awards extra lives at a fixed kill interval, and flags a landed enemy as a player hit and game over. It drives the player's hit-enemy, hit and add-life inputs and the enemy's hit input, which are currently tied to constants.

## Interface
- `life_interval_p`, default 10: kills per extra life; legal range 1..255.
- `clk_i`  in  1  pixel clock; the only clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `frame_i`  in  1  one-cycle strobe during vertical blank; positions are stable while it is high.
- `bullet_valid_i`  in  1  player bullet is in flight.
- `bullet_left_i`, `bullet_right_i`, `bullet_top_i`, `bullet_bot_i`  in  10 each  bullet box edges.
- `enemy_left_i`, `enemy_right_i`, `enemy_top_i`, `enemy_bot_i`  in  10 each  enemy box edges.
- `enemy_dead_i`  in  1  enemy is already destroyed.
- `enemy_landed_i`  in  1  enemy has reached the player row.
- `hit_enemy_o`  out  1  pulse to the player: the bullet struck and must be retired.
- `enemy_hit_o`  out  1  pulse to the enemy: it was struck.
- `player_hit_o`  out  1  pulse to the player: the player was hit.
- `add_life_o`  out  1  pulse to the player: award one life.
- `game_over_o`  out  1  sticky flag; cleared only by reset.
- `score_bcd_o`  out  16  four BCD digits; `[15:12]` is the thousands digit.

## Operation
- The FSM has four states: IDLE, EVAL, HIT and LOCKOUT.
- **IDLE**
  - On `frame_i`=1, register all eight box edges, `bullet_valid_i` and `enemy_dead_i`, then go to EVAL.
  - `frame_i` is ignored in every other state.
- **EVAL**
  - Overlap rule: `bl < er && el < br && bt < eb && et < bb`, using registered values. Unsigned 10-bit compares; strict inequalities, so boxes that only share an edge do not overlap.
  - If overlap && valid && !dead && !`game_over_o`, go to HIT. Otherwise go to IDLE.
- **HIT** (one cycle)
  - Register `hit_enemy_o`=`enemy_hit_o`=1 for exactly one cycle.
  - Increment the score and the kill counter.
  - Go to LOCKOUT.
- **LOCKOUT**
  - Stay until `bullet_valid_i`=0 is sampled, then go to IDLE.
  - This prevents one bullet from scoring twice.
- **Score**
  - BCD increment by 1 with per-digit carry.
  - Saturates at 9999: a kill at 9999 leaves the score unchanged but still pulses the hit outputs.
- **Kill counter**
  - Range 0..`life_interval_p`-1.
  - On the increment that would reach `life_interval_p`, wrap to 0 and pulse `add_life_o` for one cycle.
  - This is independent of score saturation.
- **Landing**
  - A rising edge of `enemy_landed_i` (registered previous value) pulses `player_hit_o` for one cycle and sets `game_over_o`.
  - This path runs independently of the FSM.
  - A landing in the same cycle as HIT: both take effect.
  - While `game_over_o`=1, EVAL never enters HIT.
- **Reset** (any state, mid-operation included):
  - FSM returns to IDLE.
  - All outputs go to 0; score = 0x0000; kill counter = 0; landed-edge register = 0.

## Timing
- `frame_i` sampled at edge k:
  - EVAL during cycle k+1.
  - `hit_*_o` and `add_life_o` high during cycle k+2 only; the score shows the new value from cycle k+2.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `player_hit_o`: high one cycle after the edge where `enemy_landed_i`=1 is first sampled (previous value 0).
- `game_over_o`: set in the same cycle as `player_hit_o`.
- Maximum hit rate: one per frame. A `frame_i` arriving during EVAL, HIT or LOCKOUT is dropped.

## Structure
- `game_pkg` holds:
  - the `collision_state_e` enum (IDLE, EVAL, HIT, LOCKOUT);
  - the `bcd_digit_t` typedef (logic [3:0]);
  - `SCORE_MAX_C` = 16'h9999.
- Sub-module `bcd_counter4`:
  - ports: `clk_i`, `reset_i`, `inc_i`, `count_o[15:0]`;
  - saturating 4-digit BCD increment.
- The kill counter and landing-edge logic are inline in `collision_scorer`.

## Test plan
- **Direct hit:**
  - Stimulus: bullet 300..306 × 200..210, enemy 290..330 × 190..220, valid=1, then `frame_i`.
  - Response: `hit_enemy_o` and `enemy_hit_o` high exactly at cycle k+2; score becomes 0x0001.
- **Edge touch / miss:**
  - Stimulus: `bullet_right_i`=290, `enemy_left_i`=290.
  - Response: no pulse. Repeat with `enemy_dead_i`=1 and with valid=0: no pulse in either case.
- **Lockout:**
  - Stimulus: keep the overlap and valid=1 across 3 frames.
  - Response: one hit only. Drop valid for one cycle, then the next frame hits again; score is 2.
- **Life award:**
  - Stimulus: `life_interval_p`=3; perform 7 kills.
  - Response: `add_life_o` pulses on kills 3 and 6 only.
- **Saturation:**
  - Stimulus: drive 10000 kills, or preload via a bench force to 0x9998 and hit twice.
  - Response: score holds at 0x9999; the hit pulses still occur.
- **Landing and reset:**
  - Stimulus: raise `enemy_landed_i` for 5 cycles.
  - Response: `player_hit_o` pulses once; `game_over_o` is sticky; later overlaps produce no hits. Assert `reset_i` in LOCKOUT: all outputs and the score return to 0 on the next edge.
